// File: rtl/ascon_pack.sv
// Shared types and constants for the Ascon permutation control path.
// Holds the FSM encoding and the supported round counts.
package ascon_pack;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] ROUNDS_12  = 4'd12;
  localparam logic [3:0] ROUNDS_8   = 4'd8;
  localparam logic [3:0] ROUNDS_6   = 4'd6;
  localparam logic [3:0] LAST_ROUND = 4'd11;

  function automatic logic [3:0] rounds_of(input logic [1:0] sel);
    logic [3:0] n;
    case (sel)
      2'b01:   n = ROUNDS_8;
      2'b10:   n = ROUNDS_6;
      default: n = ROUNDS_12;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/round_counter.sv
// 4-bit loadable up-counter tracking the permutation round index.
// Load takes priority over enable.
module round_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       enable,
  output logic [3:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/permutation_ctrl.sv
// Round sequencer for the Ascon permutation: IDLE -> RUN (N rounds) -> DONE.
// All outputs decode from the state register and round counter only.
module permutation_ctrl
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [1:0] rounds_sel_i,
  output logic [3:0] round_o,
  output logic       en_reg_state_o,
  output logic       sel_init_o,
  output logic       busy_o,
  output logic       done_o
);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] n_q;
  logic [3:0] n_sel;
  logic [3:0] cnt;
  logic       load;
  logic       cnt_en;

  assign n_sel = rounds_of(rounds_sel_i);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      n_q     <= ROUNDS_12;
    end else begin
      state_q <= state_d;
      if (load) begin
        n_q <= n_sel;
      end
    end
  end

  round_counter u_round_counter (
    .clock      (clock_i),
    .reset      (reset_i),
    .load       (load),
    .load_value (ROUNDS_12 - n_sel),
    .enable     (cnt_en),
    .count      (cnt)
  );

  always_comb begin
    state_d        = state_q;
    load           = 1'b0;
    cnt_en         = 1'b0;
    round_o        = 4'd0;
    en_reg_state_o = 1'b0;
    sel_init_o     = 1'b0;
    busy_o         = 1'b0;
    done_o         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        en_reg_state_o = 1'b1;
        busy_o         = 1'b1;
        round_o        = cnt;
        // First round of a run is the one the counter was loaded with.
        sel_init_o     = (cnt == (ROUNDS_12 - n_q));
        if (cnt == LAST_ROUND) begin
          state_d = DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        done_o = 1'b1;
        if (start_i) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_permutation_ctrl.sv
// Directed self-checking bench for permutation_ctrl.
// Outputs are packed as {round, en_reg_state, sel_init, busy, done}.
module tb_permutation_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] rsel;
  logic [3:0] round;
  logic       en_reg;
  logic       sel_init;
  logic       busy;
  logic       done;
  logic [7:0] outs;

  int tests;
  int fails;

  permutation_ctrl dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .start_i        (start),
    .rounds_sel_i   (rsel),
    .round_o        (round),
    .en_reg_state_o (en_reg),
    .sel_init_o     (sel_init),
    .busy_o         (busy),
    .done_o         (done)
  );

  assign outs = {round, en_reg, sel_init, busy, done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [7:0] EXP_IDLE = 8'h00;
  localparam logic [7:0] EXP_DONE = 8'h01;

  function automatic logic [7:0] exp_run(input int r, input bit first);
    logic [3:0] rr;
    rr = r[3:0];
    return {rr, 1'b1, first, 1'b1, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller sets start/rsel; this samples the start and walks every round.
  task automatic do_run(input int first, input bit noisy, input string tag);
    step();
    for (int r = first; r <= 11; r++) begin
      chk($sformatf("%s_r%0d", tag, r), outs, exp_run(r, r == first));
      start = noisy && (r != 11);
      if (noisy) rsel = rsel + 2'd1;
      step();
    end
    chk({tag, "_done"}, outs, EXP_DONE);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    start = 1'b0;
    rsel  = 2'b00;
    #3;
    chk("reset_async", outs, EXP_IDLE);
    step();
    chk("reset_hold", outs, EXP_IDLE);
    rst = 1'b0;
    step();
    chk("idle_0", outs, EXP_IDLE);
    step();
    chk("idle_1", outs, EXP_IDLE);

    start = 1'b1; rsel = 2'b00;
    do_run(0, 1'b0, "r12");
    start = 1'b0;
    step();
    chk("r12_idle", outs, EXP_IDLE);

    start = 1'b1; rsel = 2'b10;
    do_run(6, 1'b0, "r6");
    step();
    chk("r6_idle", outs, EXP_IDLE);

    start = 1'b1; rsel = 2'b01;
    do_run(4, 1'b0, "r8");
    start = 1'b1; rsel = 2'b00;
    do_run(0, 1'b0, "b2b");
    step();
    chk("b2b_idle", outs, EXP_IDLE);

    start = 1'b1; rsel = 2'b00;
    do_run(0, 1'b1, "noisy");
    step();
    chk("noisy_idle", outs, EXP_IDLE);

    start = 1'b1; rsel = 2'b11;
    do_run(0, 1'b0, "rsv");
    step();
    chk("rsv_idle", outs, EXP_IDLE);

    start = 1'b1; rsel = 2'b00;
    step();
    start = 1'b0;
    for (int r = 0; r < 5; r++) step();
    chk("mid_r5", outs, exp_run(5, 1'b0));
    #2;
    rst = 1'b1;
    #1;
    chk("mid_reset", outs, EXP_IDLE);
    step();
    chk("mid_reset_hold", outs, EXP_IDLE);
    rst = 1'b0;
    step();
    chk("post_reset_idle", outs, EXP_IDLE);

    rst = 1'b1;
    #2;
    rst   = 1'b0;
    start = 1'b1;
    rsel  = 2'b10;
    do_run(6, 1'b0, "post_rel");
    start = 1'b0;
    step();
    chk("post_rel_idle", outs, EXP_IDLE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/permutation_ctrl.md
PERMUTATION_CTRL -- requirements
Module: permutation_ctrl

Interface
REQ-001 The port clock_i SHALL be an input, 1 bit wide, and SHALL be the single clock; every register samples on its rising edge.
REQ-002 The port reset_i SHALL be an input, 1 bit wide, and SHALL be an asynchronous, active-high reset.
REQ-003 The port start_i SHALL be an input, 1 bit wide, that requests one permutation run; it is sampled only in IDLE or DONE.
REQ-004 The port rounds_sel_i SHALL be a 2-bit input selecting the round count: 00 gives 12, 01 gives 8, 10 gives 6, and 11 (reserved) is treated as 12.
REQ-005 The port round_o SHALL be a 4-bit output carrying the round index for the constant-addition layer, in the range 0..11.
REQ-006 The port en_reg_state_o SHALL be a 1-bit output that enables the 320-bit state register.
REQ-007 The port sel_init_o SHALL be a 1-bit output; when it is 1, the state mux selects the external input state rather than the permutation feedback.
REQ-008 The port busy_o SHALL be a 1-bit output that is 1 whenever the FSM is in RUN.
REQ-009 The port done_o SHALL be a 1-bit output that pulses high for one cycle when a run completes.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-011 In IDLE with start_i=1, the block SHALL latch the round count N from rounds_sel_i, load the round counter with 12-N, and enter RUN on the next edge.
REQ-012 In IDLE with start_i=0, the FSM SHALL remain in IDLE and the round counter SHALL hold its value.
REQ-013 In RUN, en_reg_state_o SHALL be 1 every cycle, and round_o SHALL equal the round counter.
REQ-014 In RUN, the round counter SHALL increment by 1 per cycle.
REQ-015 sel_init_o SHALL be 1 only in the first RUN cycle of each run, and 0 in all other cycles.
REQ-016 When the counter equals 11 in RUN, the next state SHALL be DONE; the counter SHALL never exceed 11 and SHALL never wrap to 0 inside a run.
REQ-017 Latency SHALL be fixed: if start_i is sampled at edge t, RUN occupies cycles t+1..t+N and done_o is 1 in cycle t+N+1 only.
REQ-018 In DONE, done_o SHALL be 1, and en_reg_state_o, busy_o and sel_init_o SHALL be 0.
REQ-019 In DONE with start_i=0, the next state SHALL be IDLE.
REQ-020 In DONE with start_i=1, the block SHALL accept a back-to-back start: it latches the new N, loads the counter with 12-N, and goes directly to RUN.
REQ-021 start_i asserted during RUN SHALL be ignored; it SHALL be neither queued nor allowed to alter N or the counter.
REQ-022 A change on rounds_sel_i during RUN SHALL have no effect, because N is used only as latched at start.
REQ-023 In IDLE, round_o SHALL be 0, and en_reg_state_o, sel_init_o, busy_o and done_o SHALL be 0.

Reset
REQ-024 Asserting reset_i SHALL immediately force IDLE, a round counter of 0, a latched N of 12, and all outputs to 0, independent of clock_i.
REQ-025 Reset asserted mid-run SHALL abort the run with no done_o pulse; after reset is released, the block SHALL wait for a new start_i.
REQ-026 The first rising edge after reset_i deasserts SHALL be able to accept start_i.

Structure
REQ-027 The FSM state enum (IDLE, RUN, DONE) and the constants for round counts 12, 8 and 6 SHALL be defined in the shared ascon_pack package.
REQ-028 The 4-bit loadable, enabled up-counter SHALL be a separate sub-module, round_counter, with inputs load, load value and enable.
REQ-029 All outputs SHALL be decoded from registered state and counter values only, so no output has a combinational path from start_i.

Verification
REQ-030 Scenario, 12-round run: start_i=1 for one cycle with rounds_sel_i=00 -> busy_o high for 12 cycles, round_o steps 0,1,...,11, sel_init_o high only with round_o=0, done_o high in cycle 13.
REQ-031 Scenario, 6-round run: rounds_sel_i=10 -> round_o steps 6..11, en_reg_state_o high for exactly 6 cycles, then one done_o pulse.
REQ-032 Scenario, 8-round back-to-back run: a run with rounds_sel_i=01, then start_i=1 during its DONE cycle with rounds_sel_i=00 -> the next cycle is RUN with round_o=0 and sel_init_o=1, with no IDLE cycle in between.
REQ-033 Scenario, stimulus during RUN: start_i held at 1 and rounds_sel_i toggled throughout a 12-round run -> exactly one done_o pulse and round_o unaffected.
REQ-034 Scenario, reset mid-run: reset_i asserted between clock edges while round_o=5 -> all outputs 0 immediately, no done_o pulse, and a fresh run succeeds after release.
REQ-035 Scenario, reserved encoding: rounds_sel_i=11 -> identical behaviour to 00, with 12 rounds from round_o=0.
